// File: rtl/pipe_pkg.sv
// Shared pipeline types: header byte array, egress port mask and the FIFO entry
// that carries both between processor stages.
package pipe_pkg;

  // Bus widths shared by every processor stage of the pipeline
  localparam int BYTE_BUS    = 8;
  localparam int HDR_MAX_LEN = 4;
  localparam int NUM_PORTS   = 4;
  localparam int DROP_CNT_W  = 16;

  // Element [0] is the first header byte on the wire
  typedef logic [HDR_MAX_LEN-1:0][BYTE_BUS-1:0] hdr_t;
  typedef logic [NUM_PORTS-1:0]                 port_t;

  typedef struct packed {
    hdr_t  hdr;
    port_t port;
  } hdr_entry_t;

endpackage

// File: rtl/pkt_hdr_fifo_if.sv
// Push/pop/status bundle between a header producer, the header FIFO and its consumer.
interface pkt_hdr_fifo_if import pipe_pkg::*; #(
  parameter int DEPTH = 4
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  wr_i;
  hdr_t                  pkt_hdr_i;
  port_t                 out_port_i;
  logic                  full_o;
  logic                  afull_o;
  logic                  rd_i;
  logic                  empty_o;
  hdr_t                  pkt_hdr_o;
  port_t                 out_port_o;
  logic [CNT_W-1:0]      count_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;
  logic                  err_ovf_o;
  logic                  err_udf_o;
  logic                  clear_err_i;

  modport master (
    output wr_i, pkt_hdr_i, out_port_i, rd_i, clear_err_i,
    input  full_o, afull_o, empty_o, pkt_hdr_o, out_port_o,
    input  count_o, drop_cnt_o, err_ovf_o, err_udf_o
  );

  modport slave (
    input  wr_i, pkt_hdr_i, out_port_i, rd_i, clear_err_i,
    output full_o, afull_o, empty_o, pkt_hdr_o, out_port_o,
    output count_o, drop_cnt_o, err_ovf_o, err_udf_o
  );

endinterface

// File: rtl/pkt_hdr_fifo.sv
// Show-ahead FIFO of {header, egress port mask} between pipeline processor stages,
// with occupancy, almost-full, saturating drop counter and sticky error flags.
module pkt_hdr_fifo import pipe_pkg::*; #(
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic           clk,
  input  logic           rst,
  pkt_hdr_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  hdr_entry_t            mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [DROP_CNT_W-1:0] drop_cnt_r;
  logic                  err_ovf_r;
  logic                  err_udf_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  ovf_evt_s;
  logic                  udf_evt_s;
  hdr_entry_t            head_s;
  hdr_entry_t            wr_entry_s;

  assign empty_s    = (count_r == CNT_W'(0));
  assign full_s     = (count_r == CNT_W'(DEPTH));
  // A push against a full FIFO is dropped even if a pop frees a slot this cycle
  assign push_s     = bus.wr_i & ~full_s;
  assign pop_s      = bus.rd_i & ~empty_s;
  assign ovf_evt_s  = bus.wr_i & full_s;
  assign udf_evt_s  = bus.rd_i & empty_s;
  assign wr_entry_s = '{hdr: bus.pkt_hdr_i, port: bus.out_port_i};

  // Head entry falls through while non-empty, forced to zero when empty
  always_comb begin
    head_s = '0;
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  // Entry storage: no reset so it stays a plain inferable RAM
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Debug counters: an error event in the clear cycle takes priority over the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_r <= DROP_CNT_W'(0);
      err_ovf_r  <= 1'b0;
      err_udf_r  <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        err_ovf_r <= 1'b1;
        if (bus.clear_err_i) begin
          drop_cnt_r <= DROP_CNT_W'(1);
        end else if (drop_cnt_r != {DROP_CNT_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
        end
      end else if (bus.clear_err_i) begin
        err_ovf_r  <= 1'b0;
        drop_cnt_r <= DROP_CNT_W'(0);
      end
      if (udf_evt_s) begin
        err_udf_r <= 1'b1;
      end else if (bus.clear_err_i) begin
        err_udf_r <= 1'b0;
      end
    end
  end

  assign bus.empty_o    = empty_s;
  assign bus.full_o     = full_s;
  assign bus.afull_o    = (count_r >= CNT_W'(AFULL_THRESH));
  assign bus.count_o    = count_r;
  assign bus.pkt_hdr_o  = head_s.hdr;
  assign bus.out_port_o = head_s.port;
  assign bus.drop_cnt_o = drop_cnt_r;
  assign bus.err_ovf_o  = err_ovf_r;
  assign bus.err_udf_o  = err_udf_r;

endmodule
